riscv_processor: RTL and testbench

RISCV_PROCESSOR -- requirements
Module: riscv_processor

---
 rtl/riscv_processor.sv | 105 ++++++++++
 tb/tb_riscv_processor.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_processor.sv
// Single-cycle RV32I integer core (R-type and OP-IMM only): no PC, no fetch,
// one externally supplied instruction retires on every rising clock edge.
module riscv_processor (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instruction,
   input  logic [4:0]  dbg_addr,
   output logic [31:0] dbg_data,
   output logic        wb_en,
   output logic [4:0]  wb_addr,
   output logic [31:0] wb_data,
   output logic        illegal
);

   localparam logic [6:0] OP_REG = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] F7_STD = 7'b0000000;
   localparam logic [6:0] F7_ALT = 7'b0100000;

   logic [31:0] regs [0:31];

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] imm;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [4:0]  shamt;
   logic        is_reg;
   logic        use_alt;
   logic        illegal_op;
   logic [31:0] alu_result;

   assign opcode  = instruction[6:0];
   assign funct3  = instruction[14:12];
   assign funct7  = instruction[31:25];
   assign rs1     = instruction[19:15];
   assign rs2     = instruction[24:20];
   assign wb_addr = instruction[11:7];
   assign imm     = {{20{instruction[31]}}, instruction[31:20]};
   assign is_reg  = (opcode == OP_REG);
   assign use_alt = instruction[30];

   // Register 0 is never written, so guarding the read keeps x0 at zero.
   assign op_a     = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
   assign op_b     = is_reg ? ((rs2 == 5'd0) ? 32'd0 : regs[rs2]) : imm;
   assign shamt    = op_b[4:0];
   assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : regs[dbg_addr];

   // Legality: only SUB/SRA(I) may carry the alternate funct7 encoding.
   always_comb begin
      illegal_op = 1'b0;
      case (opcode)
         OP_REG: begin
            if (funct7 == F7_STD)
               illegal_op = 1'b0;
            else if (funct7 == F7_ALT && (funct3 == 3'd0 || funct3 == 3'd5))
               illegal_op = 1'b0;
            else
               illegal_op = 1'b1;
         end
         OP_IMM: begin
            if (funct3 == 3'd1)
               illegal_op = (funct7 != F7_STD);
            else if (funct3 == 3'd5)
               illegal_op = (funct7 != F7_STD) && (funct7 != F7_ALT);
            else
               illegal_op = 1'b0;
         end
         default: illegal_op = 1'b1;
      endcase
   end

   always_comb begin
      alu_result = 32'd0;
      case (funct3)
         3'd0: alu_result = (is_reg && use_alt) ? (op_a - op_b) : (op_a + op_b);
         3'd1: alu_result = op_a << shamt;
         3'd2: alu_result = {31'd0, ($signed(op_a) < $signed(op_b))};
         3'd3: alu_result = {31'd0, (op_a < op_b)};
         3'd4: alu_result = op_a ^ op_b;
         3'd5: alu_result = use_alt ? 32'($signed(op_a) >>> shamt) : (op_a >> shamt);
         3'd6: alu_result = op_a | op_b;
         3'd7: alu_result = op_a & op_b;
         default: alu_result = 32'd0;
      endcase
   end

   assign illegal = illegal_op;
   assign wb_data = alu_result;
   assign wb_en   = !illegal_op && (wb_addr != 5'd0) && rst_n;

   // Reset preloads x[i] = i; otherwise the retiring instruction writes back.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++)
            regs[i] <= 32'(i);
      end else if (wb_en) begin
         regs[wb_addr] <= wb_data;
      end
   end

endmodule

// File: tb/tb_riscv_processor.sv
// Directed bench for riscv_processor: hand-computed register contents after
// reset, R-type and I-type sequences, illegal encodings and reset override.
module tb_riscv_processor;

   logic        clk;
   logic        rst_n;
   logic [31:0] instruction;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        illegal;

   int checks;
   int errors;
   logic [31:0] expRegs [0:31];

   riscv_processor dut (
      .clk(clk),
      .rst_n(rst_n),
      .instruction(instruction),
      .dbg_addr(dbg_addr),
      .dbg_data(dbg_data),
      .wb_en(wb_en),
      .wb_addr(wb_addr),
      .wb_data(wb_data),
      .illegal(illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Drive inputs and let combinational outputs settle before the next edge.
   task automatic applyStimulus(input logic [31:0] ins, input logic rn);
      instruction = ins;
      rst_n       = rn;
      #1;
   endtask

   // Retire the applied instruction, then park on an illegal opcode so that
   // later debug reads can span clock edges without changing state.
   task automatic tick();
      @(posedge clk);
      #1;
      instruction = 32'h0000_0000;
      rst_n       = 1'b1;
   endtask

   task automatic execute(input logic [31:0] ins);
      applyStimulus(ins, 1'b1);
      tick();
   endtask

   task automatic checkReg(input int idx, input logic [31:0] expected);
      dbg_addr = 5'(idx);
      #1;
      checkOutput($sformatf("x%0d", idx), dbg_data, expected);
   endtask

   task automatic checkAllRegs();
      for (int i = 0; i < 32; i++)
         checkReg(i, expRegs[i]);
   endtask

   task automatic loadResetModel();
      for (int i = 0; i < 32; i++)
         expRegs[i] = 32'(i);
      expRegs[0] = 32'd0;
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      instruction = 32'h0;
      rst_n       = 1'b0;
      dbg_addr    = 5'd0;

      // Reset state
      @(negedge clk);
      applyStimulus(32'h0000_0000, 1'b0);
      tick();
      loadResetModel();
      checkAllRegs();

      // R-type sequence
      applyStimulus(32'h0010_80B3, 1'b1);
      checkOutput("add_wb_en", 32'(wb_en), 32'd1);
      checkOutput("add_wb_addr", 32'(wb_addr), 32'd1);
      checkOutput("add_wb_data", wb_data, 32'd2);
      tick();
      execute(32'h4021_0133);
      execute(32'h0031_91B3);
      execute(32'h0042_2233);
      execute(32'h0052_B2B3);
      execute(32'h0063_4333);
      execute(32'h0073_D3B3);
      execute(32'h4084_5433);
      execute(32'h0094_E4B3);
      execute(32'h00A5_7533);
      expRegs[1] = 32'd2;  expRegs[2] = 32'd0;  expRegs[3] = 32'd24;
      expRegs[4] = 32'd0;  expRegs[5] = 32'd0;  expRegs[6] = 32'd0;
      expRegs[7] = 32'd0;  expRegs[8] = 32'd0;  expRegs[9] = 32'd9;
      expRegs[10] = 32'd10;
      checkAllRegs();

      // I-type sequence
      execute(32'h0010_8093);
      execute(32'h0021_2113);
      execute(32'h0031_B193);
      execute(32'h0042_4213);
      execute(32'h0052_E293);
      execute(32'h0063_7313);
      execute(32'h0073_9393);
      execute(32'h0084_5413);
      execute(32'h4094_D493);
      expRegs[1] = 32'd3;  expRegs[2] = 32'd1;  expRegs[3] = 32'd0;
      expRegs[4] = 32'd4;  expRegs[5] = 32'd5;  expRegs[6] = 32'd0;
      expRegs[7] = 32'd0;  expRegs[8] = 32'd0;  expRegs[9] = 32'd0;
      checkAllRegs();

      // Unsupported opcode and funct7 encodings leave state untouched
      applyStimulus(32'h1122_3344, 1'b1);
      checkOutput("badop_illegal", 32'(illegal), 32'd1);
      checkOutput("badop_wb_en", 32'(wb_en), 32'd0);
      tick();
      applyStimulus(32'h0210_80B3, 1'b1);
      checkOutput("badf7_illegal", 32'(illegal), 32'd1);
      checkOutput("badf7_wb_en", 32'(wb_en), 32'd0);
      tick();
      applyStimulus(32'h4010_9093, 1'b1);
      checkOutput("badslli_illegal", 32'(illegal), 32'd1);
      tick();
      applyStimulus(32'h4020_E133, 1'b1);
      checkOutput("bador_illegal", 32'(illegal), 32'd1);
      tick();
      checkAllRegs();

      // x0 destination and x0 read
      applyStimulus(32'h0000_0000, 1'b0);
      tick();
      loadResetModel();
      applyStimulus(32'h0050_0013, 1'b1);
      checkOutput("x0dst_wb_en", 32'(wb_en), 32'd0);
      checkOutput("x0dst_illegal", 32'(illegal), 32'd0);
      checkOutput("x0dst_wb_data", wb_data, 32'd5);
      tick();
      checkReg(0, 32'd0);
      execute(32'h4010_00B3);
      checkReg(1, 32'hFFFF_FFFF);

      // Signed compare and shift boundaries on x1 = -1
      execute(32'h0000_A113);
      checkReg(2, 32'd1);
      execute(32'hFFF0_B193);
      checkReg(3, 32'd0);
      execute(32'h41F0_D213);
      checkReg(4, 32'hFFFF_FFFF);
      execute(32'h01F0_D293);
      checkReg(5, 32'd1);
      checkReg(6, 32'd6);

      // Reset overrides a concurrently applied write
      applyStimulus(32'h0010_80B3, 1'b0);
      checkOutput("rst_wb_en", 32'(wb_en), 32'd0);
      tick();
      checkReg(1, 32'd1);
      checkReg(2, 32'd2);
      checkReg(31, 32'd31);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
